// File: rtl/lampFPU_pkg.sv
// Shared types and constants for the iterative logarithm unit.
// Width-dependent encodings are stored left-aligned in 64 bits and sliced by the user.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  // ln(2) as an unsigned Q0.64 fraction; slicing the top bits gives a truncated constant
  localparam logic [63:0] LAMP_LN2_Q64    = 64'hB17217F7D1CF79AB;
  localparam logic [63:0] LAMP_INF_E_Q64  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] LAMP_QNAN_F_Q64 = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ITER,
    ST_SCALE,
    ST_NORM,
    ST_DONE
  } log_state_e;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NEG_INF,
    SP_POS_INF,
    SP_QNAN
  } log_special_e;

  function automatic int exp_bias(int e_dw);
    return (1 << (e_dw - 1)) - 1;
  endfunction

endpackage

// File: rtl/lamp_fpu_log_iter_if.sv
// Request/operand/result bundle of the logarithm unit.
interface lamp_fpu_log_iter_if
  import lampFPU_pkg::*;
#(
  parameter int E_DW = LAMP_FLOAT_E_DW,
  parameter int F_DW = LAMP_FLOAT_F_DW
);
  logic            doLog_i;
  logic            mode_i;
  logic            s_op_i;
  logic [E_DW-1:0] e_op_i;
  logic [F_DW-1:0] f_op_i;
  logic            isZ_op_i;
  logic            isInf_op_i;
  logic            isSNAN_op_i;
  logic            isQNAN_op_i;
  logic            isDN_op_i;
  logic            s_res_o;
  logic [E_DW-1:0] e_res_o;
  logic [F_DW-1:0] f_res_o;
  logic            valid_o;
  logic            busy_o;
  logic            isToRound_o;
  logic            isOverflow_o;
  logic            isUnderflow_o;

  modport master (
    output doLog_i, mode_i, s_op_i, e_op_i, f_op_i,
           isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i, isDN_op_i,
    input  s_res_o, e_res_o, f_res_o, valid_o, busy_o,
           isToRound_o, isOverflow_o, isUnderflow_o
  );

  modport slave (
    input  doLog_i, mode_i, s_op_i, e_op_i, f_op_i,
           isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i, isDN_op_i,
    output s_res_o, e_res_o, f_res_o, valid_o, busy_o,
           isToRound_o, isOverflow_o, isUnderflow_o
  );
endinterface

// File: rtl/lamp_fpu_log_lzc.sv
// Leading-one detector over the fixed-point magnitude used for normalisation.
module lamp_fpu_log_lzc #(
  parameter int W  = 19,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  mag,
  output logic [PW-1:0] pos,
  output logic          zero
);
  always_comb begin
    pos  = '0;
    zero = (mag == '0);
    for (int unsigned i = 0; i < W; i++) begin
      if (mag[i]) pos = PW'(i);
    end
  end
endmodule

// File: rtl/lamp_fpu_log_iter.sv
// Iterative log2/ln: integer part from the exponent, fraction bits by repeated
// squaring of the mantissa, optional ln2 scaling, then float normalisation.
module lamp_fpu_log_iter
  import lampFPU_pkg::*;
#(
  parameter int E_DW = LAMP_FLOAT_E_DW,
  parameter int F_DW = LAMP_FLOAT_F_DW,
  parameter int ITER = 10
) (
  input logic               clk,
  input logic               rst,
  lamp_fpu_log_iter_if.slave io
);
  localparam int FB   = F_DW + ITER;
  localparam int W    = E_DW + 1 + ITER;
  localparam int PW   = $clog2(W);
  localparam int CW   = $clog2(ITER);
  localparam int BIAS = exp_bias(E_DW);
  localparam logic [FB-1:0]   LN2_C  = LAMP_LN2_Q64[63 -: FB];
  localparam logic [E_DW-1:0] INF_E  = LAMP_INF_E_Q64[63 -: E_DW];
  localparam logic [F_DW-1:0] QNAN_F = LAMP_QNAN_F_Q64[63 -: F_DW];

  log_state_e          state;
  logic                mode;
  logic [CW-1:0]       cnt;
  logic [FB:0]         y;
  logic signed [E_DW:0] ipart;
  logic [ITER-2:0]     fbits;
  logic signed [W-1:0] fx;

  log_special_e        sp;
  logic [FB+1:0]       sq_t;
  logic                sq_bit;
  logic [FB:0]         y_next;
  logic [W-1:0]        mag;
  logic [W-1:0]        scaled_mag;
  logic signed [W-1:0] fx_scaled;
  logic [PW-1:0]       lead_pos;
  logic                lead_zero;
  logic [W-2:0]        nrm;
  logic [E_DW-1:0]     e_n;
  logic [F_DW-1:0]     f_n;
  logic                rnd_n;

  always_comb begin
    sp = SP_NONE;
    if (io.isSNAN_op_i || io.isQNAN_op_i) sp = SP_QNAN;
    else if (io.isZ_op_i || io.isDN_op_i) sp = SP_NEG_INF;
    else if (io.s_op_i)                   sp = SP_QNAN;
    else if (io.isInf_op_i)               sp = SP_POS_INF;
  end

  // y in [1,2) squared lands in [1,4); the integer bit of the truncated square is the next result bit
  always_comb begin
    sq_t   = (FB+2)'(((2*FB+2)'(y) * (2*FB+2)'(y)) >> FB);
    sq_bit = sq_t[FB+1];
    y_next = sq_bit ? sq_t[FB+1:1] : sq_t[FB:0];
  end

  // Scaling works on the magnitude so positive and negative results truncate symmetrically
  always_comb begin
    mag        = fx[W-1] ? W'(-fx) : W'(fx);
    scaled_mag = W'(((W+FB)'(mag) * (W+FB)'(LN2_C)) >> FB);
    fx_scaled  = fx[W-1] ? -scaled_mag : scaled_mag;
  end

  lamp_fpu_log_lzc #(
    .W  (W),
    .PW (PW)
  ) u_lzc (
    .mag  (mag),
    .pos  (lead_pos),
    .zero (lead_zero)
  );

  // Shift the leading one out of the top so the remaining bits are fraction then sticky
  always_comb begin
    nrm   = (W-1)'(mag << (PW'(W-1) - lead_pos));
    f_n   = nrm[W-2 -: F_DW];
    rnd_n = |nrm[W-2-F_DW:0];
    e_n   = E_DW'(BIAS + int'(lead_pos) - ITER);
  end

  assign io.isOverflow_o  = 1'b0;
  assign io.isUnderflow_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode           <= 1'b0;
      cnt            <= '0;
      y              <= '0;
      ipart          <= '0;
      fbits          <= '0;
      fx             <= '0;
      io.s_res_o     <= 1'b0;
      io.e_res_o     <= '0;
      io.f_res_o     <= '0;
      io.valid_o     <= 1'b0;
      io.busy_o      <= 1'b0;
      io.isToRound_o <= 1'b0;
    end else begin
      io.valid_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (io.doLog_i && !io.busy_o) begin
            io.busy_o <= 1'b1;
            mode      <= io.mode_i;
            if (sp != SP_NONE) begin
              state          <= ST_DONE;
              io.valid_o     <= 1'b1;
              io.isToRound_o <= 1'b0;
              io.s_res_o     <= (sp == SP_NEG_INF);
              io.e_res_o     <= INF_E;
              io.f_res_o     <= (sp == SP_QNAN) ? QNAN_F : '0;
            end else begin
              state <= ST_ITER;
              y     <= {1'b1, io.f_op_i, {ITER{1'b0}}};
              ipart <= (E_DW+1)'({1'b0, io.e_op_i}) - (E_DW+1)'(BIAS);
            end
          end
        end
        ST_ITER: begin
          y     <= y_next;
          fbits <= {fbits[ITER-3:0], sq_bit};
          if (cnt == CW'(ITER-1)) begin
            cnt   <= '0;
            fx    <= {ipart, fbits, sq_bit};
            state <= mode ? ST_SCALE : ST_NORM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SCALE: begin
          fx    <= fx_scaled;
          state <= ST_NORM;
        end
        ST_NORM: begin
          state      <= ST_DONE;
          io.valid_o <= 1'b1;
          if (lead_zero) begin
            io.s_res_o     <= 1'b0;
            io.e_res_o     <= '0;
            io.f_res_o     <= '0;
            io.isToRound_o <= 1'b0;
          end else begin
            io.s_res_o     <= fx[W-1];
            io.e_res_o     <= e_n;
            io.f_res_o     <= f_n;
            io.isToRound_o <= rnd_n;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          io.busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lamp_fpu_log_iter.sv
// Scoreboard bench for lamp_fpu_log_iter at bfloat16 widths with ITER=10.
module tb_lamp_fpu_log_iter;

  typedef struct {
    bit       s;
    bit [7:0] e;
    bit [6:0] f;
    bit       z, inf, snan, qnan, dn, mode;
  } op_t;

  typedef struct {
    bit       s;
    bit [7:0] e;
    bit [6:0] f;
    bit       rnd;
    bit       chk_rnd;
    int       lat;
    int       acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  bit   prev_valid = 1'b0;

  lamp_fpu_log_iter_if #(.E_DW(8), .F_DW(7)) io ();

  lamp_fpu_log_iter #(.E_DW(8), .F_DW(7), .ITER(10)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic op_t mk_op(bit s, bit [7:0] e, bit [6:0] f, bit z, bit inf,
                                bit snan, bit qnan, bit dn, bit mode);
    op_t o;
    o.s = s; o.e = e; o.f = f; o.z = z; o.inf = inf;
    o.snan = snan; o.qnan = qnan; o.dn = dn; o.mode = mode;
    return o;
  endfunction

  function automatic exp_t mk_exp(bit s, bit [7:0] e, bit [6:0] f, bit rnd, bit chk_rnd, int lat);
    exp_t x;
    x.s = s; x.e = e; x.f = f; x.rnd = rnd; x.chk_rnd = chk_rnd; x.lat = lat; x.acc = 0;
    return x;
  endfunction

  // Reference: log2 via the squaring rule on plain integers, ln via truncated ln2 scaling
  function automatic exp_t model(op_t o);
    exp_t   r;
    longint y, x, mag, ln2q;
    int     k, bits, p;
    r = mk_exp(0, 8'h00, 7'h00, 0, 0, 1);
    if (o.snan || o.qnan)  begin r.e = 8'hFF; r.f = 7'h40; end
    else if (o.z || o.dn)  begin r.s = 1; r.e = 8'hFF; end
    else if (o.s)          begin r.e = 8'hFF; r.f = 7'h40; end
    else if (o.inf)        begin r.e = 8'hFF; end
    else begin
      r.chk_rnd = 1;
      r.lat = o.mode ? 13 : 12;
      k = int'(o.e) - 127;
      y = longint'({1'b1, o.f}) << 10;
      bits = 0;
      for (int i = 0; i < 10; i++) begin
        y = (y * y) >> 17;
        bits = bits * 2;
        if (y >= 64'sd262144) begin
          bits++;
          y = y / 2;
        end
      end
      x = longint'(k) * 1024 + bits;
      if (o.mode) begin
        ln2q = longint'($floor(0.6931471805599453 * 131072.0));
        mag = (x < 0) ? -x : x;
        mag = (mag * ln2q) / 131072;
        x = (x < 0) ? -mag : mag;
      end
      if (x != 0) begin
        r.s = (x < 0);
        mag = (x < 0) ? -x : x;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        r.e = 8'(127 + p - 10);
        if (p >= 7) begin
          r.f   = 7'((mag >> (p - 7)) & 127);
          r.rnd = ((mag & ((64'sd1 << (p - 7)) - 1)) != 0);
        end else begin
          r.f = 7'((mag << (7 - p)) & 127);
        end
      end
    end
    return r;
  endfunction

  task automatic set_inputs(op_t o);
    io.s_op_i      = o.s;
    io.e_op_i      = o.e;
    io.f_op_i      = o.f;
    io.isZ_op_i    = o.z;
    io.isInf_op_i  = o.inf;
    io.isSNAN_op_i = o.snan;
    io.isQNAN_op_i = o.qnan;
    io.isDN_op_i   = o.dn;
    io.mode_i      = o.mode;
  endtask

  task automatic scramble();
    op_t o;
    o = mk_op(1'($urandom), 8'($urandom), 7'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    set_inputs(o);
  endtask

  task automatic issue(op_t o, exp_t x);
    bit ok = 0;
    @(negedge clk);
    set_inputs(o);
    io.doLog_i = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (!io.busy_o) begin
        x.acc = cyc + 1;
        sb.push_back(x);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: busy_o stuck at 1, required 0");
    end
    @(negedge clk);
    io.doLog_i = 1'b0;
    scramble();
    chk("busy_after_accept", io.busy_o, 1);
  endtask

  function automatic op_t rand_op();
    op_t o;
    int  r = $urandom_range(0, 99);
    o = mk_op(0, 8'h00, 7'($urandom), 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    if (r < 20)      o.e = 8'($urandom_range(125, 129));
    else if (r < 66) o.e = 8'($urandom_range(1, 254));
    else if (r < 74) begin o.s = 1; o.e = 8'($urandom_range(1, 254)); end
    else if (r < 80) begin o.s = 1'($urandom); o.f = 0; o.z = 1; end
    else if (r < 86) begin o.s = 1'($urandom); o.f = o.f | 7'h01; o.dn = 1; end
    else if (r < 92) begin o.s = 1'($urandom); o.e = 8'hFF; o.f = 0; o.inf = 1; end
    else begin
      o.s = 1'($urandom); o.e = 8'hFF;
      if (r < 96) begin o.f = o.f | 7'h01; o.snan = 1; o.f[6] = 0; end
      else begin o.f = o.f | 7'h40; o.qnan = 1; end
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (io.valid_o) begin
        chk("valid_pulse_width", prev_valid, 0);
        chk("busy_in_done", io.busy_o, 1);
        chk("overflow", io.isOverflow_o, 0);
        chk("underflow", io.isUnderflow_o, 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid_o=1 with no request outstanding, required 0");
        end else begin
          cur = sb.pop_front();
          chk("s_res", io.s_res_o, cur.s);
          chk("e_res", io.e_res_o, cur.e);
          chk("f_res", io.f_res_o, cur.f);
          if (cur.chk_rnd) chk("isToRound", io.isToRound_o, cur.rnd);
          chk("latency", cyc - cur.acc + 1, cur.lat);
        end
      end else begin
        if (prev_valid) chk("busy_after_done", io.busy_o, 0);
        if (sb.size() > 0 && (cyc - sb[0].acc) > 40) begin
          checks++; errors++;
          $display("FAIL valid_timeout: got no valid_o within 40 cycles, required latency %0d", sb[0].lat);
          void'(sb.pop_front());
        end
      end
      prev_valid = io.valid_o;
    end
  end

  initial begin
    op_t  two;
    exp_t two_x;
    int   accepts;
    io.doLog_i = 1'b0;
    set_inputs(mk_op(0, 8'h00, 7'h00, 0, 0, 0, 0, 0, 0));
    two   = mk_op(0, 8'h80, 7'h00, 0, 0, 0, 0, 0, 0);
    two_x = mk_exp(0, 8'h7F, 7'h00, 0, 1, 12);

    repeat (3) @(negedge clk);
    chk("rst_valid", io.valid_o, 0);
    chk("rst_busy", io.busy_o, 0);
    chk("rst_s", io.s_res_o, 0);
    chk("rst_e", io.e_res_o, 0);
    chk("rst_f", io.f_res_o, 0);
    chk("rst_round", io.isToRound_o, 0);
    rst = 1'b0;

    issue(two, two_x);
    issue(mk_op(0, 8'h82, 7'h00, 0, 0, 0, 0, 0, 0), mk_exp(0, 8'h80, 7'h40, 0, 1, 12));
    issue(mk_op(0, 8'h7E, 7'h00, 0, 0, 0, 0, 0, 0), mk_exp(1, 8'h7F, 7'h00, 0, 1, 12));
    issue(mk_op(0, 8'h7F, 7'h00, 0, 0, 0, 0, 0, 0), mk_exp(0, 8'h00, 7'h00, 0, 1, 12));
    issue(mk_op(0, 8'h80, 7'h00, 0, 0, 0, 0, 0, 1), mk_exp(0, 8'h7E, 7'h31, 1, 1, 13));
    issue(mk_op(0, 8'h00, 7'h00, 1, 0, 0, 0, 0, 0), mk_exp(1, 8'hFF, 7'h00, 0, 0, 1));
    issue(mk_op(1, 8'h80, 7'h00, 0, 0, 0, 0, 0, 0), mk_exp(0, 8'hFF, 7'h40, 0, 0, 1));
    issue(mk_op(0, 8'hFF, 7'h00, 0, 1, 0, 0, 0, 0), mk_exp(0, 8'hFF, 7'h00, 0, 0, 1));
    issue(mk_op(0, 8'hFF, 7'h05, 0, 0, 1, 0, 0, 1), mk_exp(0, 8'hFF, 7'h40, 0, 0, 1));

    // request held high across a whole operation
    @(negedge clk);
    set_inputs(two);
    io.doLog_i = 1'b1;
    accepts = 0;
    for (int n = 0; n < 60 && accepts < 2; n++) begin
      if (!io.busy_o) begin
        two_x.acc = cyc + 1;
        sb.push_back(two_x);
        accepts++;
      end
      @(negedge clk);
    end
    io.doLog_i = 1'b0;
    chk("hold_accepts", accepts, 2);

    // reset in the middle of iterating
    issue(two, two_x);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", io.valid_o, 0);
    chk("midrst_busy", io.busy_o, 0);
    chk("midrst_s", io.s_res_o, 0);
    chk("midrst_e", io.e_res_o, 0);
    chk("midrst_f", io.f_res_o, 0);
    chk("midrst_round", io.isToRound_o, 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(two, two_x);

    for (int i = 0; i < 60; i++) begin
      op_t o = rand_op();
      issue(o, model(o));
    end

    for (int n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
    chk("drain_outstanding", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
